// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - round-robin arbiter sharing one sync-read memory among NUM_REQ requesters
// Supports locked (atomic) sequences with an idle-timeout forced release.
module shared_mem_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_mask,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  input  logic [DATA_WIDTH-1:0]           core_in_mem_data_out,
  output logic [DATA_WIDTH-1:0]           core_out_mem_addr_in,
  output logic [DATA_WIDTH-1:0]           core_out_mem_data_in,
  output logic                            core_out_mem_we_in,
  output logic [DATA_WIDTH/8-1:0]         core_out_mem_mask_in
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [NUM_REQ-1:0] rsp_pend_q;

  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W:0]     scan;

  // Grant selection: in LOCKED only the owner may win, otherwise rotate from rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    if (state_q == LOCKED) begin
      gnt_any = req_valid[owner_q];
      gnt_idx = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
        if (scan >= NUM_REQ_W) scan = scan - NUM_REQ_W;
        if (!gnt_any && req_valid[scan[IDX_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = scan[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready            = '0;
    core_out_mem_addr_in = '0;
    core_out_mem_data_in = '0;
    core_out_mem_we_in   = 1'b0;
    core_out_mem_mask_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && gnt_idx == IDX_W'(i)) begin
        req_ready[i]         = 1'b1;
        core_out_mem_addr_in = req_addr[i*DATA_WIDTH +: DATA_WIDTH];
        core_out_mem_data_in = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        core_out_mem_we_in   = req_we[i];
        core_out_mem_mask_in = req_mask[i*MASK_W +: MASK_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    idle_cnt_d = idle_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    if (gnt_any) rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    case (state_q)
      IDLE: begin
        if (gnt_any && req_lock[gnt_idx]) begin
          state_d    = LOCKED;
          owner_d    = gnt_idx;
          idle_cnt_d = '0;
        end
      end
      LOCKED: begin
        // An owner grant always beats an expiring counter.
        if (gnt_any) begin
          idle_cnt_d = '0;
          if (!req_lock[gnt_idx]) state_d = IDLE;
        end else if (idle_cnt_q == CNT_MAX) begin
          state_d    = IDLE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      idle_cnt_q <= '0;
      rr_ptr_q   <= '0;
      rsp_pend_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      idle_cnt_q <= idle_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_pend_q <= req_ready;
    end
  end

  assign rsp_valid = rsp_pend_q;
  assign rsp_rdata = core_in_mem_data_out;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - scoreboard bench for shared_mem_arbiter with a sync-read memory model
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_we = '0, req_lock = '0;
  logic [31:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0;
  logic [3:0]  m0 = '0, m1 = '0;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_mask;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata, mem_rdata, mem_addr, mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_mask;

  logic        mem_load = 1'b1;
  logic [31:0] tb_mem [0:63];

  typedef struct {
    logic [1:0]  onehot;
    logic        we;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  assign req_addr  = {a1, a0};
  assign req_wdata = {d1, d0};
  assign req_mask  = {m1, m0};

  always #5 clk = ~clk;

  shared_mem_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .LOCK_TIMEOUT(4)) dut (
    .clk                  (clk),
    .arst_n               (arst_n),
    .req_valid            (req_valid),
    .req_we               (req_we),
    .req_lock             (req_lock),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .req_mask             (req_mask),
    .req_ready            (req_ready),
    .rsp_valid            (rsp_valid),
    .rsp_rdata            (rsp_rdata),
    .core_in_mem_data_out (mem_rdata),
    .core_out_mem_addr_in (mem_addr),
    .core_out_mem_data_in (mem_wdata),
    .core_out_mem_we_in   (mem_we),
    .core_out_mem_mask_in (mem_mask)
  );

  always @(posedge clk) begin
    if (mem_load) begin
      for (int w = 0; w < 64; w++) tb_mem[w] <= 32'h0;
      tb_mem[4]  <= 32'hA5A5_0001;
      tb_mem[16] <= 32'hDEAD_BEEF;
      tb_mem[32] <= 32'hCAFE_BABE;
      mem_rdata  <= '0;
    end else begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) tb_mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= tb_mem[mem_addr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after the negedge drive: checks the grant, queues the response, checks the response.
  task automatic step(input logic [1:0] exp_ready, input string tag);
    exp_t e;
    logic [31:0] ea;
    #1;
    check({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
    ea = exp_ready[1] ? a1 : (exp_ready[0] ? a0 : 32'h0);
    check({tag, ".addr"}, 64'(mem_addr), 64'(ea));
    check({tag, ".we"}, 64'(mem_we),
          64'(exp_ready[1] ? req_we[1] : (exp_ready[0] ? req_we[0] : 1'b0)));
    if (exp_ready != 2'b00) begin
      e.onehot = exp_ready;
      e.we     = exp_ready[1] ? req_we[1] : req_we[0];
      e.rdata  = tb_mem[ea[7:2]];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(e.onehot));
      if (!e.we) check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
    end else begin
      check({tag, ".rsp_idle"}, 64'(rsp_valid), 64'h0);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk);
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    mem_load = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;

    // Reset state with no requests.
    drive(2'b00, 2'b00, 2'b00);
    #1;
    check("reset.data", 64'(mem_wdata), 64'h0);
    check("reset.mask", 64'(mem_mask), 64'h0);
    check("reset.rsp", 64'(rsp_valid), 64'h0);
    #0 step(2'b00, "reset");

    // Round robin with both requesters reading.
    a0 = 32'h10; a1 = 32'h40;
    drive(2'b11, 2'b00, 2'b00); step(2'b01, "rr0");
    drive(2'b11, 2'b00, 2'b00); step(2'b10, "rr1");
    drive(2'b11, 2'b00, 2'b00); step(2'b01, "rr2");
    drive(2'b11, 2'b00, 2'b00); step(2'b10, "rr3");

    // Read path: requester 1 alone.
    drive(2'b10, 2'b00, 2'b00); step(2'b10, "read1");

    // Lock for three accesses, release on the fourth.
    drive(2'b11, 2'b00, 2'b01); step(2'b01, "lock0");
    drive(2'b11, 2'b00, 2'b01); step(2'b01, "lock1");
    drive(2'b11, 2'b00, 2'b01); step(2'b01, "lock2");
    drive(2'b11, 2'b00, 2'b00); step(2'b01, "unlock");
    drive(2'b11, 2'b00, 2'b00); step(2'b10, "after_unlock");

    // Timeout: lock grant, then owner idle; requester 1 wins 5 cycles later.
    drive(2'b11, 2'b00, 2'b01); step(2'b01, "to_lock");
    for (int c = 0; c < 4; c++) begin
      drive(2'b10, 2'b00, 2'b00); step(2'b00, "to_wait");
    end
    drive(2'b10, 2'b00, 2'b00); step(2'b10, "to_release");

    // Owner request in the expiring cycle keeps the lock.
    drive(2'b11, 2'b00, 2'b01); step(2'b01, "ex_lock");
    for (int c = 0; c < 3; c++) begin
      drive(2'b10, 2'b00, 2'b00); step(2'b00, "ex_wait");
    end
    drive(2'b11, 2'b00, 2'b01); step(2'b01, "ex_hold");
    drive(2'b10, 2'b00, 2'b00); step(2'b00, "ex_still_locked");
    drive(2'b11, 2'b00, 2'b00); step(2'b01, "ex_unlock");
    drive(2'b11, 2'b00, 2'b00); step(2'b10, "ex_after");

    // Locked masked write from requester 1, then reset while its response is out.
    a1 = 32'h80; d1 = 32'h1234_5678; m1 = 4'b0011;
    drive(2'b10, 2'b10, 2'b10);
    #1;
    check("wr.data", 64'(mem_wdata), 64'h1234_5678);
    check("wr.mask", 64'(mem_mask), 64'h3);
    #0 step(2'b10, "wr");
    req_valid = 2'b00; req_we = 2'b00; req_lock = 2'b00;
    arst_n = 1'b0;
    #1;
    check("rst.rsp_valid", 64'(rsp_valid), 64'h0);
    check("mem_masked", 64'(tb_mem[32]), 64'hCAFE_5678);
    @(negedge clk);
    arst_n = 1'b1;
    a0 = 32'h80;
    drive(2'b01, 2'b00, 2'b00); step(2'b01, "rst_lock_released");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
